seg_scan_driver: RTL

- Parametrised successor to the six-digit 7-segment display multiplexer.
- Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus, with an active-low digit-select bus.
- Scan rate comes from an internal prescaler, so the block runs on the fast clock instead of a pre-divided clock.
- Adds per-digit decimal point, per-digit blanking, leading-zero suppression, tear-free frame snapshots and a frame-done pulse; sits between the wave-generator status registers and the board display pins.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment lookup for the seg_scan_driver slice.
// Segment bit order is {g,f,e,d,c,b,a}. The decimal point is added by the driver.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to 7-segment decoder, {g,f,e,d,c,b,a} active-high.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg7
);

    assign seg7 = seg_hex(nib);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with prescaler, tear-free frame snapshots,
// DP/blanking and leading-zero suppression. Optional PWM dimming under SEG_SCAN_DIM_EN.
// The active-low digit select is named bit_sel because `bit` is a reserved word.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk_seg,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   bit_sel,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]             presc;
    logic [IW-1:0]             idx;
    logic [IW-1:0]             next_idx;
    logic                      tick;
    logic                      wrap;

    logic [4*NUM_DIGITS-1:0]   snap_data;
    logic [NUM_DIGITS-1:0]     snap_dp;
    logic [NUM_DIGITS-1:0]     snap_blank;
    logic                      snap_lz;

    logic [4*NUM_DIGITS-1:0]   eff_data;
    logic [NUM_DIGITS-1:0]     eff_dp;
    logic [NUM_DIGITS-1:0]     eff_blank;
    logic                      eff_lz;

    logic [NUM_DIGITS-1:0]     supp;
    logic                      zero_run;
    logic [3:0]                nib;
    logic                      cur_dp;
    logic                      cur_blank;
    logic                      cur_supp;
    logic [NUM_DIGITS-1:0]     sel_n;
    logic [6:0]                hex7;
    logic [7:0]                seg_next;
    logic [7:0]                seg_q;

    assign tick     = (presc == PRESC_LAST);
    assign next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign wrap     = tick && (next_idx == '0);

    // Digit 0 is encoded on the same edge that loads the snapshot, so it reads the live inputs.
    assign eff_data  = wrap ? digit_data : snap_data;
    assign eff_dp    = wrap ? dp_mask    : snap_dp;
    assign eff_blank = wrap ? blank_mask : snap_blank;
    assign eff_lz    = wrap ? lz_en      : snap_lz;

    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (eff_data[4*i +: 4] == 4'h0);
            if (i != 0) supp[i] = eff_lz & zero_run;
        end
    end

    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        sel_n     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (next_idx == IW'(i)) begin
                nib       = eff_data[4*i +: 4];
                cur_dp    = eff_dp[i];
                cur_blank = eff_blank[i];
                cur_supp  = supp[i];
                sel_n[i]  = 1'b0;
            end
        end
    end

    seg_hex_decode u_dec (
        .nib  (nib),
        .seg7 (hex7)
    );

    assign seg_next = (cur_blank || cur_supp) ? SEG_BLANK : {cur_dp, hex7};

    always_ff @(posedge clk_seg or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= IDX_LAST;
            snap_data  <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            snap_lz    <= 1'b0;
            seg_q      <= SEG_BLANK;
            bit_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            presc      <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx     <= next_idx;
                bit_sel <= sel_n;
                seg_q   <= seg_next;
            end
            if (wrap) begin
                snap_data  <= digit_data;
                snap_dp    <= dp_mask;
                snap_blank <= blank_mask;
                snap_lz    <= lz_en;
            end
        end
    end

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk_seg or posedge rst) begin
        if (rst) pwm_cnt <= 4'h0;
        else     pwm_cnt <= pwm_cnt + 4'h1;
    end

    assign seg = (pwm_cnt > brightness) ? SEG_BLANK : seg_q;
`else
    assign seg = seg_q;
`endif

endmodule
